// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-source result FIFOs, round-robin grant and a
// registered broadcast that the reservation stations and register status table snoop.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int SRC_W  = $clog2(N_SRC)
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      flush,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*TAG_W-1:0]    src_tag,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TAG_W + DATA_W;

  logic [EW-1:0]     mem_q [N_SRC][DEPTH];
  logic [CW-1:0]     cnt_q [N_SRC];
  logic [PW-1:0]     rd_q  [N_SRC];
  logic [PW-1:0]     wr_q  [N_SRC];
  logic [SRC_W-1:0]  ptr_q;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;

  logic [N_SRC-1:0]  push_s;
  logic [N_SRC-1:0]  pop_s;
  logic              gnt_s;
  logic [SRC_W-1:0]  gnt_idx_s;
  logic [SRC_W-1:0]  scan_s;
  logic [SRC_W-1:0]  ptr_d;
  logic [EW-1:0]     head_s;
  int                scan_int_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Ready looks only at the registered count, never at a same-cycle pop.
  always_comb begin
    src_ready = '0;
    push_s    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = (cnt_q[i] != CW'(DEPTH));
      push_s[i]    = src_valid[i] & src_ready[i];
    end
  end

  // Round-robin search starting at ptr_q over non-empty FIFOs.
  always_comb begin
    gnt_s      = 1'b0;
    gnt_idx_s  = '0;
    scan_int_s = 0;
    scan_s     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_int_s = int'(ptr_q) + k;
      if (scan_int_s >= N_SRC) begin
        scan_int_s = scan_int_s - N_SRC;
      end else begin
        scan_int_s = scan_int_s;
      end
      scan_s = SRC_W'(scan_int_s);
      if (!gnt_s && (cnt_q[scan_s] != '0)) begin
        gnt_s     = 1'b1;
        gnt_idx_s = scan_s;
      end else begin
        gnt_s     = gnt_s;
      end
    end
  end

  // Pop decode, head entry of the granted FIFO and next round-robin pointer.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pop_s[i] = gnt_s && (gnt_idx_s == SRC_W'(i));
    end
    head_s = mem_q[gnt_idx_s][rd_q[gnt_idx_s]];
    if (gnt_idx_s == SRC_W'(N_SRC - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_s + SRC_W'(1);
    end
  end

  // FIFO state, round-robin pointer and the registered CDB.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= '0;
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
      end
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= '0;
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
      end
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push_s[i]) begin
          mem_q[i][wr_q[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
          wr_q[i]           <= ptr_inc(wr_q[i]);
        end
        if (pop_s[i]) begin
          rd_q[i] <= ptr_inc(rd_q[i]);
        end
        if (push_s[i] && !pop_s[i]) begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end else if (pop_s[i] && !push_s[i]) begin
          cnt_q[i] <= cnt_q[i] - CW'(1);
        end
      end
      if (gnt_s) begin
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= head_s[EW-1:DATA_W];
        cdb_data_q  <= head_s[DATA_W-1:0];
        cdb_src_q   <= gnt_idx_s;
        ptr_q       <= ptr_d;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter and broadcaster for the Tomasulo core. Collects completed results (tag + data) from the functional units through per-source buffers, selects one per cycle by round-robin, and drives the registered CDB that reservation stations and the register status table snoop. Flush support discards in-flight results on branch mispredict.

## Interface
- N_SRC, 3, number of result sources (ALU, MUL/DIV, LOAD); must be ≥ 2
- TAG_W, 4, reservation-station tag width
- DATA_W, 32, result data width
- DEPTH, 2, per-source buffer entries; must be a power of two and ≥ 1
- SRC_W, $clog2(N_SRC), width of the source index

- clk  in  1  single clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all buffered and pending results
- src_valid  in  N_SRC  per-source result valid
- src_tag  in  N_SRC*TAG_W  flattened tags; source i occupies [i*TAG_W +: TAG_W]
- src_data  in  N_SRC*DATA_W  flattened data; source i occupies [i*DATA_W +: DATA_W]
- src_ready  out  N_SRC  per-source buffer not full
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast data
- cdb_src  out  SRC_W  index of the granted source

## Operation
- Each source has a DEPTH-entry FIFO holding {tag, data}, with a count of 0..DEPTH.
- A push occurs when src_valid[i] && src_ready[i].
- src_ready[i] = (count_i != DEPTH).
  - It depends only on registered count, not on a same-cycle pop.
  - A full FIFO therefore refuses input even when it is granted that cycle.
- Arbitration is combinational over non-empty FIFOs.
  - Search order is ptr, ptr+1, …, wrapping mod N_SRC.
  - The first non-empty FIFO found is granted.
- On a grant to source g:
  - Pop the head of FIFO g.
  - Register {1, head tag, head data, g} onto the CDB outputs.
  - Set ptr to (g+1) mod N_SRC.
- With no grant: cdb_valid goes to 0, tag/data/src hold their previous values, and ptr holds.
- Simultaneous push and pop on the same FIFO in one cycle:
  - count is unchanged.
  - The pushed entry is ordered after all existing entries.
- Read and write pointers wrap mod DEPTH.
- Within each source, results broadcast in FIFO order. The CDB never carries two results in one cycle.
- flush (when RST is low) takes effect at the next edge:
  - All counts and FIFO pointers go to 0, ptr goes to 0, and cdb_valid goes to 0.
  - Pushes presented in the flush cycle are dropped.
  - No grant is issued in the flush cycle.
- RST has identical effect and also clears cdb_tag, cdb_data and cdb_src. RST has priority over flush.

## Timing
- Reset values:
  - src_ready = all 1s.
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0.
  - ptr = 0, all counts = 0.
- Uncontended latency is 2 cycles.
  - Input is accepted at edge k.
  - The FIFO is visible as non-empty in cycle k+1.
  - The granted result is registered at edge k+1, so cdb_valid = 1 during cycle k+2.
- A src_ready deassertion from a push appears the cycle after the push edge.
- Sustained throughput is one broadcast per cycle whenever any FIFO is non-empty.
- Worst-case wait for a non-empty source is N_SRC−1 grants. There is no starvation.
- Reset or flush asserted mid-operation:
  - Outputs take reset/flush values after that edge.
  - No partially drained result appears afterward.

## Test plan
- **Single result:** RST low; source 1 pushes tag 5, data 0x1234 at edge 1.
  - Required: cdb_valid=1, cdb_tag=5, cdb_data=0x1234, cdb_src=1 during cycle 3 only.
  - Required: cdb_valid=0 during cycle 4.
- **Three-way contention:** all three sources push once at the same edge with tags 1, 2, 3 (ptr=0).
  - Required: broadcasts on three consecutive cycles with cdb_src 0, 1, 2 and tags 1, 2, 3.
  - Required: ptr ends at 0.
- **Fairness:** sources 0 and 2 push continuously with ptr=0.
  - Required: grants alternate 0, 2, 0, 2, …
  - Required: no source is granted twice in a row while the other is non-empty.
- **Backpressure:** source 0 pushes every cycle while sources 1 and 2 also stay full.
  - Required: src_ready[0] drops after its FIFO holds 2 entries.
  - Required: a push offered while full is not accepted; no entry is lost or duplicated.
  - Required: per-source order is preserved (check tags 0, 1, 2, … from source 0).
- **Flush:** buffer 4 results, then assert flush for one cycle while source 1 presents tag 9.
  - Required: cdb_valid=0 the cycle after flush.
  - Required: tag 9 and all buffered results never appear.
  - Required: src_ready is all 1s.
- **Reset mid-operation:** assert RST while cdb_valid=1 and FIFOs are non-empty.
  - Required: all outputs equal reset values after the edge.
  - Required: with no new pushes, cdb_valid stays 0.
